// File: rtl/bundle_pkg.sv
// bundle_pkg: shared types and constants for the bundle reader.
//   state_e       reader FSM states
//   Fc*Bit        bit positions inside fault_code
//   ERR_MAX       saturation value of err_count
//   CNT_MAX       saturation value of the optional period counter
package bundle_pkg;

    typedef enum logic [1:0] {StIdle, StSync, StTrack, StFault} state_e;

    localparam int unsigned FcIndexBit  = 0;
    localparam int unsigned FcParityBit = 1;
    localparam int unsigned FcVectorBit = 2;

    localparam int unsigned ERR_MAX = 255;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/bundle_period_ctr.sv
// bundle_period_ctr: measures the length of the writer's sequence cycle.
// Ports:
//   clock    rising-edge clock
//   reset_n  synchronous active-low reset
//   start    first passing beat (leaving SYNC): that beat counts as 1
//   step     passing beat while tracking
//   wrap     the state after this step equals the recorded start state
//   period   last measured cycle length, 0 until measured
module bundle_period_ctr
    import bundle_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        step,
    input  logic        wrap,
    output logic [15:0] period
);

    // Beats taken since the start state was last seen.
    logic [15:0] cnt_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            period <= '0;
        end else if (start) begin
            cnt_q <= 16'd1;
        end else if (step && (cnt_q != CNT_MAX)) begin
            // A saturated counter no longer yields a meaningful period.
            if (wrap) begin
                period <= cnt_q + 16'd1;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

endmodule

// File: rtl/bundle_reader.sv
// bundle_reader: follows a writer that updates one bit of a vector per beat,
// reconstructs the vector and flags any beat inconsistent with the tracked state.
// Ports:
//   clock, reset_n      clock and synchronous active-low reset
//   b_valid             a write-back beat occurs this cycle
//   b_index             bit position written this beat
//   b_inp               writer's vector before the update
//   b_out               bit being written (expected ^b_inp)
//   resync              forces IDLE next cycle from any state
//   locked, fault       registered state indications (TRACK, FAULT)
//   fault_code          {vector, parity, index} error bits of the faulting beat
//   err_count           saturating count of faulting beats
//   shadow              reconstructed vector
//   period              sequence cycle length (0 unless BUNDLE_READER_PERIOD_EN)
// Optional feature macro: BUNDLE_READER_PERIOD_EN
module bundle_reader
    import bundle_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned IW    = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             b_valid,
    input  logic [IW-1:0]    b_index,
    input  logic [WIDTH-1:0] b_inp,
    input  logic             b_out,
    input  logic             resync,
    output logic             locked,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic [7:0]       err_count,
    output logic [WIDTH-1:0] shadow,
    output logic [15:0]      period
);

    state_e           state_q;
    logic [IW-1:0]    exp_q;
    logic [IW-1:0]    exp_inc;
    logic [IW-1:0]    idx_inc;
    logic [WIDTH-1:0] shadow_upd;
    logic [2:0]       chk;

    // WIDTH is a power of two, so IW-bit addition wraps WIDTH-1 to 0.
    assign exp_inc = exp_q + IW'(1);
    assign idx_inc = b_index + IW'(1);

    always_comb begin
        shadow_upd          = b_inp;
        shadow_upd[b_index] = b_out;
        chk                 = '0;
        chk[FcIndexBit]     = (b_index != exp_q);
        chk[FcParityBit]    = (b_out != ^b_inp);
        chk[FcVectorBit]    = (b_inp != shadow);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            exp_q      <= '0;
            shadow     <= '0;
            locked     <= 1'b0;
            fault      <= 1'b0;
            fault_code <= '0;
            err_count  <= '0;
        end else if (resync) begin
            // Takes priority over any beat in the same cycle.
            state_q    <= StIdle;
            locked     <= 1'b0;
            fault      <= 1'b0;
            fault_code <= '0;
        end else if (b_valid) begin
            case (state_q)
                StIdle: begin
                    shadow  <= shadow_upd;
                    exp_q   <= idx_inc;
                    state_q <= StSync;
                end
                StSync, StTrack: begin
                    if (|chk) begin
                        state_q    <= StFault;
                        locked     <= 1'b0;
                        fault      <= 1'b1;
                        fault_code <= chk;
                        if (err_count != 8'(ERR_MAX)) begin
                            err_count <= err_count + 8'd1;
                        end
                    end else begin
                        shadow[b_index] <= b_out;
                        exp_q           <= exp_inc;
                        state_q         <= StTrack;
                        locked          <= 1'b1;
                    end
                end
                default: ; // FAULT is sticky until resync
            endcase
        end
    end

`ifdef BUNDLE_READER_PERIOD_EN
    logic [WIDTH-1:0] start_q;
    logic [IW-1:0]    start_idx_q;
    logic             beat_pass;

    assign beat_pass = b_valid && !resync && (chk == 3'b000) &&
                       ((state_q == StSync) || (state_q == StTrack));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            start_q     <= '0;
            start_idx_q <= '0;
        end else if (!resync && b_valid && (state_q == StIdle)) begin
            start_q     <= shadow_upd;
            start_idx_q <= idx_inc;
        end
    end

    bundle_period_ctr u_period_ctr (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (beat_pass && (state_q == StSync)),
        .step    (beat_pass && (state_q == StTrack)),
        .wrap    ((shadow_upd == start_q) && (exp_inc == start_idx_q)),
        .period  (period)
    );
`else
    assign period = '0;
`endif

endmodule
